// File: rtl/unflatten_pkg.sv
// Shared CNN tensor helpers: the flatten and unflatten blocks derive their sizes
// and their element ordering from these definitions.
package unflatten_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } ufl_state_e;

    function automatic int calc_total(input int width, input int height, input int channels);
        return width * height * channels;
    endfunction

    // Counter width for 'total' positions, never narrower than one bit.
    function automatic int calc_idx_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    // Serial position of element (ch, y, x); x varies fastest.
    function automatic int elem_index(input int ch, input int y, input int x,
                                      input int width, input int height);
        return (ch * height + y) * width + x;
    endfunction

    function automatic int word_offset(input int index, input int bitwidth);
        return index * bitwidth;
    endfunction

endpackage

// File: rtl/unflatten.sv
// Collects a serial element stream into one wide tensor word, with a single frame
// of overlap between collection and the pending output.
module unflatten
    import unflatten_pkg::*;
#(
    parameter int BITWIDTH    = 16,
    parameter int DATAWIDTH   = 14,
    parameter int DATAHEIGHT  = 14,
    parameter int DATACHANNEL = 3
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 clken,
    input  logic [BITWIDTH-1:0]                                  data_in,
    input  logic                                                 data_in_valid,
    output logic                                                 data_in_ready,
    output logic [BITWIDTH*DATAWIDTH*DATAHEIGHT*DATACHANNEL-1:0] data_out,
    output logic                                                 data_out_valid,
    input  logic                                                 data_out_ready,
    output logic                                                 done
);

    localparam int TOTAL  = calc_total(DATAWIDTH, DATAHEIGHT, DATACHANNEL);
    localparam int IDXW   = calc_idx_width(TOTAL);
    localparam int FRAMEW = TOTAL * BITWIDTH;
    localparam int OFFW   = calc_idx_width(FRAMEW);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOTAL - 1);

    logic [IDXW-1:0]   idx_q, idx_d;
    ufl_state_e        state_q;
    logic [FRAMEW-1:0] buf_q;
    logic [FRAMEW-1:0] frame_d;
    logic [FRAMEW-1:0] data_out_q;
    logic              done_q;
    logic [OFFW-1:0]   wr_off;
    logic              at_last, accept, last_accept, out_xfer;

    assign at_last     = (idx_q == LAST_IDX);
    // Only the final word of a frame has to wait for the previous tensor to leave.
    assign data_in_ready = clken && (rst || !(at_last && state_q == HOLD && !data_out_ready));
    assign accept      = clken && data_in_valid && data_in_ready;
    assign last_accept = accept && at_last;
    assign out_xfer    = clken && (state_q == HOLD) && data_out_ready;
    assign idx_d       = at_last ? '0 : idx_q + IDXW'(1);
    assign wr_off      = OFFW'(word_offset(int'(idx_q), BITWIDTH));

    always_comb begin
        // NOTE: default first, then override, so no path leaves frame_d unassigned (no latch).
        frame_d = buf_q;
        frame_d[word_offset(TOTAL - 1, BITWIDTH) +: BITWIDTH] = data_in;
    end

    // NOTE: the collection buffer is deliberately not reset; every slot is rewritten
    // before it can reach data_out, so a reset would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (accept && !at_last) begin
            buf_q[wr_off +: BITWIDTH] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            state_q    <= FILL;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else if (clken) begin
            done_q <= last_accept;
            if (accept) begin
                idx_q <= idx_d;
            end
            case (state_q)
                FILL: begin
                    if (last_accept) begin
                        data_out_q <= frame_d;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (last_accept) begin
                        data_out_q <= frame_d;
                    end else if (out_xfer) begin
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = (state_q == HOLD);
    assign done           = done_q;

endmodule

// File: tb/tb_unflatten.sv
// Self-checking bench for unflatten (2x2x3 tensor of 16-bit words): directed vectors
// and sequences, then random traffic against a stream-level reference model.
module tb_unflatten;

    localparam int BW    = 16;
    localparam int W     = 2;
    localparam int H     = 2;
    localparam int C     = 3;
    localparam int TOTAL = W * H * C;
    localparam int FW    = BW * TOTAL;

    logic          clk;
    logic          rst;
    logic          clken;
    logic [BW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [FW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          done;

    int checks = 0;
    int errors = 0;

    unflatten #(
        .BITWIDTH   (BW),
        .DATAWIDTH  (W),
        .DATAHEIGHT (H),
        .DATACHANNEL(C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clken         (clken),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, FW'(act), FW'(exp));
    endtask

    // Element k of a frame whose words are base+1, base+2, ...
    function automatic logic [FW-1:0] make_frame(input logic [BW-1:0] base);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < TOTAL; k++) f[k*BW +: BW] = base + BW'(k + 1);
        return f;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and return after the edge that takes it (or after a bounded wait).
    task automatic send(input logic [BW-1:0] w, output int waited);
        data_in       = w;
        data_in_valid = 1'b1;
        waited        = 0;
        @(negedge clk);
        while (!(clken && data_in_ready) && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 100) check1("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    // Reference model: a list of collected words and one pending output tensor.
    logic [BW-1:0] words_m[$];
    logic [FW-1:0] out_m   = '0;
    logic          valid_m = 1'b0;
    logic          done_m  = 1'b0;
    logic          mon_en  = 1'b0;

    always @(negedge clk) begin : monitor
        logic exp_rdy, acc, xfer, fin;
        if (mon_en) begin
            check1("mon_out_valid", data_out_valid, valid_m);
            check1("mon_done", done, done_m);
            if (valid_m) check("mon_data_out", data_out, out_m);
            exp_rdy = clken && (rst || !(words_m.size() == TOTAL - 1 && valid_m && !data_out_ready));
            check1("mon_in_ready", data_in_ready, exp_rdy);
            if (rst) begin
                words_m.delete();
                out_m   = '0;
                valid_m = 1'b0;
                done_m  = 1'b0;
            end else if (clken) begin
                acc  = data_in_valid && exp_rdy;
                xfer = valid_m && data_out_ready;
                fin  = 1'b0;
                if (acc) begin
                    words_m.push_back(data_in);
                    if (words_m.size() == TOTAL) begin
                        for (int k = 0; k < TOTAL; k++) out_m[k*BW +: BW] = words_m[k];
                        words_m.delete();
                        fin = 1'b1;
                    end
                end
                if (fin) valid_m = 1'b1;
                else if (xfer) valid_m = 1'b0;
                done_m = fin;
            end
        end
    end

    typedef struct {
        logic          clken;
        logic          in_valid;
        logic [BW-1:0] in_data;
        logic          out_ready;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic          exp_done;
    } vec_t;

    vec_t vecs[14];

    initial begin : main
        int waited;

        for (int i = 0; i < TOTAL; i++)
            vecs[i] = '{1'b1, 1'b1, BW'(i + 1), 1'b1, 1'b1, (i == TOTAL - 1), (i == TOTAL - 1)};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};

        rst            = 1'b1;
        clken          = 1'b1;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        cycle();
        mon_en = 1'b1;
        check1("rst_in_ready", data_in_ready, 1'b1);
        check1("rst_out_valid", data_out_valid, 1'b0);
        check1("rst_done", done, 1'b0);
        check("rst_data_out", data_out, '0);
        cycle();
        rst = 1'b0;
        #1;
        check1("post_rst_in_ready", data_in_ready, 1'b1);

        // Single frame 0x0001..0x000C with the consumer always ready.
        for (int i = 0; i < 14; i++) begin
            clken          = vecs[i].clken;
            data_in_valid  = vecs[i].in_valid;
            data_in        = vecs[i].in_data;
            data_out_ready = vecs[i].out_ready;
            #1;
            check1("tbl_in_ready", data_in_ready, vecs[i].exp_in_ready);
            @(posedge clk);
            #1;
            check1("tbl_out_valid", data_out_valid, vecs[i].exp_out_valid);
            check1("tbl_done", done, vecs[i].exp_done);
            if (vecs[i].exp_out_valid) check("tbl_frame", data_out, make_frame(16'h0000));
        end
        clken         = 1'b1;
        data_in_valid = 1'b0;

        // Three back-to-back frames: valid exactly after words 12, 24 and 36, no stalls.
        data_out_ready = 1'b1;
        for (int i = 0; i < 3 * TOTAL; i++) begin
            send(BW'(16'h2000 + i), waited);
            check1("b2b_no_stall", (waited == 0), 1'b1);
            check1("b2b_out_valid", data_out_valid, ((i % TOTAL) == TOTAL - 1));
            if ((i % TOTAL) == TOTAL - 1)
                check("b2b_frame", data_out, make_frame(BW'(16'h2000 + i - TOTAL)));
        end
        cycle();

        // Backpressure, then an output transfer coinciding with the last-word accept.
        data_out_ready = 1'b0;
        for (int i = 0; i < TOTAL; i++) send(BW'(i + 1), waited);
        for (int i = 0; i < TOTAL - 1; i++) send(BW'(16'h0101 + i), waited);
        data_in       = 16'h010C;
        data_in_valid = 1'b1;
        #1;
        check1("bp_in_ready_low", data_in_ready, 1'b0);
        repeat (3) cycle();
        check1("bp_in_ready_held", data_in_ready, 1'b0);
        check1("bp_out_valid", data_out_valid, 1'b1);
        check("bp_frame_a_stable", data_out, make_frame(16'h0000));
        check1("bp_done_low", done, 1'b0);
        data_out_ready = 1'b1;
        #1;
        check1("bp_in_ready_release", data_in_ready, 1'b1);
        cycle();
        data_in_valid = 1'b0;
        check1("swap_out_valid", data_out_valid, 1'b1);
        check("swap_frame_b", data_out, make_frame(16'h0100));
        check1("swap_done", done, 1'b1);
        cycle();
        check1("swap_drained", data_out_valid, 1'b0);
        check1("swap_done_clear", done, 1'b0);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 5; i++) send(BW'(16'h0B01 + i), waited);
        rst = 1'b1;
        #1;
        check1("mid_rst_in_ready", data_in_ready, 1'b1);
        cycle();
        rst = 1'b0;
        check1("mid_rst_out_valid", data_out_valid, 1'b0);
        check("mid_rst_data_out", data_out, '0);
        for (int i = 0; i < TOTAL; i++) send(BW'(16'h0A01 + i), waited);
        check("mid_rst_elem0", FW'(data_out[BW-1:0]), FW'(16'h0A01));
        check("mid_rst_frame", data_out, make_frame(16'h0A00));

        // Clock-enable gap mid-frame, then done held while disabled.
        for (int i = 0; i < 4; i++) send(BW'(16'h0C01 + i), waited);
        clken         = 1'b0;
        data_in       = 16'hDEAD;
        data_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check1("gap_in_ready", data_in_ready, 1'b0);
            cycle();
            check1("gap_done", done, 1'b0);
        end
        clken = 1'b1;
        for (int i = 4; i < TOTAL; i++) send(BW'(16'h0C01 + i), waited);
        check("gap_frame", data_out, make_frame(16'h0C00));
        check1("gap_final_done", done, 1'b1);
        clken = 1'b0;
        repeat (2) cycle();
        check1("gap_done_frozen", done, 1'b1);
        check1("gap_valid_frozen", data_out_valid, 1'b1);
        clken = 1'b1;
        cycle();
        check1("gap_done_cleared", done, 1'b0);
        check1("gap_valid_cleared", data_out_valid, 1'b0);

        // Random traffic checked by the monitor's model.
        for (int i = 0; i < 1500; i++) begin
            clken          = ($urandom % 10) != 0;
            data_in_valid  = ($urandom % 3) != 0;
            data_in        = BW'($urandom);
            data_out_ready = ($urandom % 4) != 0;
            rst            = ($urandom % 250) == 0;
            cycle();
        end
        rst           = 1'b0;
        data_in_valid = 1'b0;
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
